// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - access-size type and func3 decode for the memory stage
`include "parameters.vh"

package mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Unsigned codes only exist for loads; any code without a defined meaning is a word access.
  function automatic size_e access_size(input logic [2:0] func3, input logic is_store);
    size_e sz;
    case (func3)
      `F3_LB:  sz = SZ_BYTE;
      `F3_LH:  sz = SZ_HALF;
      `F3_LBU: sz = is_store ? SZ_WORD : SZ_BYTE;
      `F3_LHU: sz = is_store ? SZ_WORD : SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane strobes, store-data replication, misalignment check
// and load lane extraction with sign/zero extension
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  i_func3,
  input  logic        i_is_store,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  input  logic [2:0]  i_ld_func3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  size_e       req_size;
  size_e       ld_size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_unsigned;

  always_comb begin
    req_size   = access_size(i_func3, i_is_store);
    o_misalign = 1'b0;
    o_wstrb    = 4'b0000;
    o_wdata    = '0;
    case (req_size)
      SZ_BYTE: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      SZ_HALF: begin
        o_misalign = i_addr_lo[0];
        o_wstrb    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_store_data[15:0]}};
      end
      default: begin
        o_misalign = |i_addr_lo;
        o_wstrb    = 4'b1111;
        o_wdata    = i_store_data;
      end
    endcase
    if (!i_is_store) begin
      o_wstrb = 4'b0000;
      o_wdata = '0;
    end
  end

  always_comb begin
    ld_size     = access_size(i_ld_func3, 1'b0);
    ld_unsigned = i_ld_func3[2];
    ld_byte     = i_rdata[8*i_ld_addr_lo +: 8];
    ld_half     = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (ld_size)
      SZ_BYTE: o_ld_data = ld_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: o_ld_data = ld_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/parameters.vh
// rtl/parameters.vh - opcode, func3 and FSM state encodings shared by the memory stage
`ifndef MEM_STAGE_PARAMETERS_VH
`define MEM_STAGE_PARAMETERS_VH

`define LD 7'b0000011
`define S  7'b0100011
`define R  7'b0110011
`define B  7'b1100011

`define F3_LB  3'b000
`define F3_LH  3'b001
`define F3_LW  3'b010
`define F3_LBU 3'b100
`define F3_LHU 3'b101
`define F3_SB  3'b000
`define F3_SH  3'b001
`define F3_SW  3'b010

`define ST_IDLE   1'b0
`define ST_ACCESS 1'b1

`endif

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: req/ack data-memory FSM with
// bus timeout, passing non-memory results straight to writeback
`include "parameters.vh"

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_result,
  input  logic [31:0] i_data_store,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_wb_en,
  output logic        o_stall,
  output logic        o_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_rd_addr,
  output logic        o_wb_en,
  output logic        o_misalign,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [0:0]       ST_IDLE      = `ST_IDLE;
  localparam logic [0:0]       ST_ACCESS    = `ST_ACCESS;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       func3_q, func3_d;
  logic [1:0]       lo_q, lo_d;
  logic [4:0]       rd_lat_q, rd_lat_d;
  logic             wb_en_lat_q, wb_en_lat_d;
  logic             valid_q, valid_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic             wb_en_q, wb_en_d;
  logic             misalign_q, misalign_d;
  logic             bus_err_q, bus_err_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      wdata_q, wdata_d;

  logic        is_load;
  logic        is_store;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        req_misalign;
  logic [31:0] ld_data;

  assign is_load  = (i_opcode == `LD);
  assign is_store = (i_opcode == `S);

  mem_align u_align (
    .i_func3      (i_func3),
    .i_is_store   (is_store),
    .i_addr_lo    (i_result[1:0]),
    .i_store_data (i_data_store),
    .o_wstrb      (req_wstrb),
    .o_wdata      (req_wdata),
    .o_misalign   (req_misalign),
    .i_ld_func3   (func3_q),
    .i_ld_addr_lo (lo_q),
    .i_rdata      (i_mem_rdata),
    .o_ld_data    (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    func3_d     = func3_q;
    lo_d        = lo_q;
    rd_lat_d    = rd_lat_q;
    wb_en_lat_d = wb_en_lat_q;
    valid_d     = 1'b0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    wb_en_d     = 1'b0;
    wb_data_d   = wb_data_q;
    rd_addr_d   = rd_addr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (!(is_load || is_store)) begin
            valid_d   = 1'b1;
            wb_data_d = i_result;
            rd_addr_d = i_rd_addr;
            wb_en_d   = i_wb_en;
          end else if (req_misalign) begin
            valid_d    = 1'b1;
            misalign_d = 1'b1;
            wb_data_d  = '0;
            rd_addr_d  = i_rd_addr;
          end else begin
            func3_d     = i_func3;
            lo_d        = i_result[1:0];
            rd_lat_d    = i_rd_addr;
            wb_en_lat_d = i_wb_en;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {i_result[31:2], 2'b00};
            wstrb_d     = req_wstrb;
            wdata_d     = req_wdata;
            cnt_d       = '0;
            state_d     = ST_ACCESS;
          end
        end
      end
      default: begin
        // An ack on the last allowed cycle still completes normally.
        if (i_mem_ack || (cnt_q == TIMEOUT_LAST)) begin
          state_d    = ST_IDLE;
          valid_d    = 1'b1;
          rd_addr_d  = rd_lat_q;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_addr_d = '0;
          wstrb_d    = 4'b0000;
          wdata_d    = '0;
          if (i_mem_ack) begin
            wb_data_d = mem_we_q ? 32'd0 : ld_data;
            wb_en_d   = !mem_we_q && wb_en_lat_q;
          end else begin
            bus_err_d = 1'b1;
            wb_data_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      func3_q     <= '0;
      lo_q        <= '0;
      rd_lat_q    <= '0;
      wb_en_lat_q <= 1'b0;
      valid_q     <= 1'b0;
      wb_data_q   <= '0;
      rd_addr_q   <= '0;
      wb_en_q     <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      func3_q     <= func3_d;
      lo_q        <= lo_d;
      rd_lat_q    <= rd_lat_d;
      wb_en_lat_q <= wb_en_lat_d;
      valid_q     <= valid_d;
      wb_data_q   <= wb_data_d;
      rd_addr_q   <= rd_addr_d;
      wb_en_q     <= wb_en_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
    end
  end

  assign o_stall     = (state_q == ST_ACCESS);
  assign o_valid     = valid_q;
  assign o_wb_data   = wb_data_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_wb_en     = wb_en_q;
  assign o_misalign  = misalign_q;
  assign o_bus_err   = bus_err_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wstrb = wstrb_q;
  assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed vector bench for mem_stage
module tb_mem_stage;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func3;
  logic [31:0] i_result;
  logic [31:0] i_data_store;
  logic [4:0]  i_rd_addr;
  logic        i_wb_en;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_wb_data;
  logic [4:0]  o_rd_addr;
  logic        o_wb_en;
  logic        o_misalign;
  logic        o_bus_err;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_opcode(i_opcode),
    .i_func3(i_func3), .i_result(i_result), .i_data_store(i_data_store),
    .i_rd_addr(i_rd_addr), .i_wb_en(i_wb_en), .o_stall(o_stall),
    .o_valid(o_valid), .o_wb_data(o_wb_data), .o_rd_addr(o_rd_addr),
    .o_wb_en(o_wb_en), .o_misalign(o_misalign), .o_bus_err(o_bus_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wstrb(o_mem_wstrb), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        wb_en;
    int          ack_wait;   // ACCESS cycle index carrying the ack; -1 = never
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    int          e_cycles;
    logic [31:0] e_data;
    logic        e_wb_en;
    logic        e_mis;
    logic        e_berr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int req_cycles;
    int stall_cycles;
    req_cycles   = 0;
    stall_cycles = 0;
    @(negedge clk);
    i_opcode = v.op; i_func3 = v.f3; i_result = v.res; i_data_store = v.sd;
    i_rd_addr = v.rd; i_wb_en = v.wb_en; i_valid = 1'b1;
    #1;
    chk({v.name, " stall_at_issue"}, 32'(o_stall), 32'd0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    if (v.e_req) begin
      chk({v.name, " req"}, 32'(o_mem_req), 32'd1);
      chk({v.name, " addr"}, o_mem_addr, v.e_addr);
      chk({v.name, " we"}, 32'(o_mem_we), 32'(v.e_we));
      chk({v.name, " wstrb"}, 32'(o_mem_wstrb), 32'(v.e_wstrb));
      if (v.e_we) chk({v.name, " wdata"}, o_mem_wdata, v.e_wdata);
      for (int g = 0; g < 40 && !o_valid; g++) begin
        if (o_mem_req) req_cycles++;
        if (o_stall) stall_cycles++;
        if (v.ack_wait == req_cycles - 1) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = v.rdata;
        end
        @(posedge clk); #1;
        i_mem_ack = 1'b0;
        i_mem_rdata = 32'd0;
      end
      chk({v.name, " req_cycles"}, 32'(req_cycles), 32'(v.e_cycles));
      chk({v.name, " stall_cycles"}, 32'(stall_cycles), 32'(v.e_cycles));
    end
    chk({v.name, " valid"}, 32'(o_valid), 32'd1);
    chk({v.name, " rd"}, 32'(o_rd_addr), 32'(v.rd));
    chk({v.name, " wb_en"}, 32'(o_wb_en), 32'(v.e_wb_en));
    chk({v.name, " misalign"}, 32'(o_misalign), 32'(v.e_mis));
    chk({v.name, " bus_err"}, 32'(o_bus_err), 32'(v.e_berr));
    chk({v.name, " req_after"}, 32'(o_mem_req), 32'd0);
    chk({v.name, " stall_after"}, 32'(o_stall), 32'd0);
    if (v.e_wb_en) chk({v.name, " wb_data"}, o_wb_data, v.e_data);
    @(posedge clk); #1;
    chk({v.name, " pulse"}, {29'd0, o_valid, o_misalign, o_bus_err}, 32'd0);
  endtask

  function automatic vec_t mk(string name, logic [6:0] op, logic [2:0] f3, logic [31:0] res,
                              logic [31:0] sd, logic [4:0] rd, logic wb_en, int ack_wait,
                              logic [31:0] rdata, logic e_req, logic [31:0] e_addr, logic e_we,
                              logic [3:0] e_wstrb, logic [31:0] e_wdata, int e_cycles,
                              logic [31:0] e_data, logic e_wb_en, logic e_mis, logic e_berr);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.res = res; v.sd = sd; v.rd = rd; v.wb_en = wb_en;
    v.ack_wait = ack_wait; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we;
    v.e_wstrb = e_wstrb; v.e_wdata = e_wdata; v.e_cycles = e_cycles; v.e_data = e_data;
    v.e_wb_en = e_wb_en; v.e_mis = e_mis; v.e_berr = e_berr;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    vecs[0]  = mk("r_type",   OP_R,  3'b000, 32'h44443555, 32'h0,        5'd5,  1'b1, -1, 32'h0,        1'b0, 32'h0,  1'b0, 4'b0000, 32'h0,        0,  32'h44443555, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk("lb_wait3", OP_LD, 3'b000, 32'h00000009, 32'h0,        5'd7,  1'b1,  3, 32'h00008000, 1'b1, 32'h8,  1'b0, 4'b0000, 32'h0,        4,  32'hFFFFFF80, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk("lbu_wait3",OP_LD, 3'b100, 32'h00000009, 32'h0,        5'd8,  1'b1,  3, 32'h00008000, 1'b1, 32'h8,  1'b0, 4'b0000, 32'h0,        4,  32'h00000080, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk("sh_hi",    OP_S,  3'b001, 32'h00000006, 32'h1234ABCD, 5'd0,  1'b1,  0, 32'h0,        1'b1, 32'h4,  1'b1, 4'b1100, 32'hABCDABCD, 1,  32'h0,        1'b0, 1'b0, 1'b0);
    vecs[4]  = mk("lw_mis",   OP_LD, 3'b010, 32'h00000002, 32'h0,        5'd9,  1'b1, -1, 32'h0,        1'b0, 32'h0,  1'b0, 4'b0000, 32'h0,        0,  32'h0,        1'b0, 1'b1, 1'b0);
    vecs[5]  = mk("lw_tmo",   OP_LD, 3'b010, 32'h00000010, 32'h0,        5'd10, 1'b1, -1, 32'h0,        1'b1, 32'h10, 1'b0, 4'b0000, 32'h0,        16, 32'h0,        1'b0, 1'b0, 1'b1);
    vecs[6]  = mk("lw_late",  OP_LD, 3'b010, 32'h00000010, 32'h0,        5'd11, 1'b1, 15, 32'hDEADBEEF, 1'b1, 32'h10, 1'b0, 4'b0000, 32'h0,        16, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk("lh_hi",    OP_LD, 3'b001, 32'h00000022, 32'h0,        5'd12, 1'b1,  1, 32'h80010000, 1'b1, 32'h20, 1'b0, 4'b0000, 32'h0,        2,  32'hFFFF8001, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk("lhu_hi",   OP_LD, 3'b101, 32'h00000022, 32'h0,        5'd13, 1'b1,  1, 32'h80010000, 1'b1, 32'h20, 1'b0, 4'b0000, 32'h0,        2,  32'h00008001, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk("sb_lane3", OP_S,  3'b000, 32'h00000013, 32'h000000A5, 5'd0,  1'b0,  2, 32'h0,        1'b1, 32'h10, 1'b1, 4'b1000, 32'hA5A5A5A5, 3,  32'h0,        1'b0, 1'b0, 1'b0);
    vecs[10] = mk("sw",       OP_S,  3'b010, 32'h00000040, 32'hCAFEF00D, 5'd0,  1'b0,  0, 32'h0,        1'b1, 32'h40, 1'b1, 4'b1111, 32'hCAFEF00D, 1,  32'h0,        1'b0, 1'b0, 1'b0);
    vecs[11] = mk("sh_mis",   OP_S,  3'b001, 32'h00000005, 32'h00001111, 5'd0,  1'b0, -1, 32'h0,        1'b0, 32'h0,  1'b0, 4'b0000, 32'h0,        0,  32'h0,        1'b0, 1'b1, 1'b0);
    vecs[12] = mk("lb_lane3", OP_LD, 3'b000, 32'h00000003, 32'h0,        5'd14, 1'b1,  0, 32'h7F000000, 1'b1, 32'h0,  1'b0, 4'b0000, 32'h0,        1,  32'h0000007F, 1'b1, 1'b0, 1'b0);
    vecs[13] = mk("b_nowb",   OP_B,  3'b000, 32'h00000123, 32'h0,        5'd3,  1'b0, -1, 32'h0,        1'b0, 32'h0,  1'b0, 4'b0000, 32'h0,        0,  32'h0,        1'b0, 1'b0, 1'b0);

    rst_n = 1'b0; i_valid = 1'b0; i_opcode = '0; i_func3 = '0; i_result = '0;
    i_data_store = '0; i_rd_addr = '0; i_wb_en = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {o_stall, o_valid, o_wb_en, o_misalign, o_bus_err, o_mem_req, o_mem_we, o_mem_wstrb},
        32'd0);
    chk("reset data", o_wb_data | o_mem_addr | o_mem_wdata | 32'(o_rd_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Reset mid-access must abort the store without a writeback pulse.
    @(negedge clk);
    i_opcode = OP_S; i_func3 = 3'b010; i_result = 32'h00000080; i_data_store = 32'h55AA55AA;
    i_rd_addr = 5'd0; i_wb_en = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("rst_acc req", 32'(o_mem_req), 32'd1);
    chk("rst_acc stall", 32'(o_stall), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_acc outputs", {o_stall, o_valid, o_wb_en, o_misalign, o_bus_err, o_mem_req, o_mem_we, o_mem_wstrb},
        32'd0);
    chk("rst_acc data", o_wb_data | o_mem_addr | o_mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_acc no_valid", {30'd0, o_valid, o_mem_req}, 32'd0);
    end
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of EX.
- Consumes the EX result (ALU value or effective address), store data, opcode and func3.
- For loads and stores it runs a req/ack transaction on the data-memory port, with byte-lane strobes, store-data lane shifting, load extraction with sign/zero extension, a misalignment check and a bus timeout.
- Non-memory ops pass straight through to writeback in one cycle.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles o_mem_req may wait for i_mem_ack before the access is aborted (≥2).
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  EX output valid this cycle.
- i_opcode  in  7  instruction opcode (`LD, `S, `R, `B, ...).
- i_func3  in  3  access size/sign: LB/LH/LW/LBU/LHU, SB/SH/SW.
- i_result  in  32  EX result; effective address for LD/S.
- i_data_store  in  32  rs2 value to store.
- i_rd_addr  in  5  destination register.
- i_wb_en  in  1  instruction writes rd.
- o_stall  out  1  upstream must hold its outputs.
- o_valid  out  1  writeback bundle valid (one-cycle pulse per instruction).
- o_wb_data  out  32  ALU result or extended load data.
- o_rd_addr  out  5  destination register.
- o_wb_en  out  1  register-file write enable (qualified by o_valid).
- o_misalign  out  1  misaligned access; pulses with o_valid.
- o_bus_err  out  1  timeout; pulses with o_valid.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  1 = store.
- o_mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- o_mem_wstrb  out  4  byte-lane write strobes.
- o_mem_wdata  out  32  lane-shifted store data.
- i_mem_ack  in  1  memory accepted/completed, one cycle.
- i_mem_rdata  in  32  read word, valid with i_mem_ack.

Behaviour:
Reset:
- Applies on the clk edge while rst_n=0.
- FSM goes to IDLE; all outputs, the counter and the latched fields go to 0.
- Reset during ACCESS drops o_mem_req on that edge and discards the access. No o_valid is produced for it.

FSM IDLE:
- o_stall=0.
- On i_valid with a non-memory opcode: next edge registers o_valid=1, o_wb_data=i_result, o_rd_addr, o_wb_en=i_wb_en. Latency 1.
- On i_valid with LD/S and a misaligned address: next edge gives o_valid=1, o_misalign=1, o_wb_en=0. No request is issued.
  - Misaligned means: LH/LHU/SH with addr[0]≠0; LW/SW with addr[1:0]≠0. Byte ops never misalign.
- On i_valid with LD/S and an aligned address: latch func3, addr[1:0], rd and wb_en.
  - Drive o_mem_req=1, o_mem_we, o_mem_addr, o_mem_wstrb and o_mem_wdata as registered outputs.
  - Clear the counter and go to ACCESS.
- i_valid=0: o_valid=0.

FSM ACCESS:
- o_stall=1 (combinational from state). Upstream inputs are ignored.
- Request outputs hold stable until ack.
- On i_mem_ack:
  - Next edge: o_mem_req=0, o_valid=1, return to IDLE.
  - Load: o_wb_data = extended lane of i_mem_rdata, o_wb_en = latched wb_en.
  - Store: o_wb_en=0.
  - Total load latency = 2 + wait cycles.
- No ack and counter = TIMEOUT_CYCLES-1: drop req; o_valid=1, o_bus_err=1, o_wb_en=0; go to IDLE.
- An ack arriving on the timeout cycle wins: normal completion.

Lane rules:
- SB: wstrb = 1<<addr[1:0]; wdata = {4{byte}}.
- SH: wstrb = 0011 or 1100; wdata = {2{half}}.
- SW: wstrb = 1111.
- LB/LH: sign-extend; LBU/LHU: zero-extend.
- Loads: o_mem_wstrb=0000.

Other:
- o_valid, o_misalign and o_bus_err are single-cycle pulses.
- Undefined func3 on LD/S is treated as a word access.

Decomposition:
- Opcode macros (`LD, `S, `R, `B) and func3 codes (LB/LH/LW/LBU/LHU/SB/SH/SW) live in rtl/parameters.vh. The FSM state encodings are added there too.
- One combinational sub-module, mem_align, covers strobe and wdata generation, misalignment detect, and load extraction/extension.
- mem_stage owns the FSM, counter and registers.

Test Plan:
- R-type, i_result=0x44443555, rd=5, wb_en=1 -> next cycle o_valid=1, o_wb_data=0x44443555, o_rd_addr=5, o_mem_req never asserted.
- LB addr 0x00000009, ack after 3 wait cycles with rdata 0x00008000 -> o_mem_addr=0x8, o_stall high 4 cycles, o_wb_data=0xFFFFFF80; same with LBU -> 0x00000080.
- SH addr 0x00000006, data 0x1234ABCD, immediate ack -> o_mem_we=1, wstrb=1100, wdata=0xABCDABCD, o_valid with o_wb_en=0.
- LW addr 0x00000002 -> no o_mem_req, next cycle o_valid=1, o_misalign=1, o_wb_en=0, o_stall stays 0.
- LW addr 0x10, ack never asserted -> o_mem_req high exactly TIMEOUT_CYCLES cycles, then o_valid=1, o_bus_err=1, FSM back to IDLE; ack on the final cycle instead -> normal completion, o_bus_err=0.
- SW in ACCESS, rst_n=0 one cycle -> o_mem_req=0 and all outputs 0 after that edge, no o_valid; next R-type completes normally.
